cu_data_read_engine_control_mc: RTL

- Multi-channel successor of the single-stream CU read-engine controller.
- Splits NUM_CHANNELS independent array-read jobs into cacheline read commands. Commands are issued one per cycle through a round-robin arbiter into the shared read command buffer.
- Tracks completions per channel and globally.
- Adds optional windowed issue: a channel issues WINDOW_CL commands, then waits for all of them to respond. This generalises the single fixed TLB-window throttle to all channels.
- Sits between the WED/job dispatch logic and the CU read command buffer / response path.

---
 rtl/cu_data_read_engine_control_mc_pkg.sv | 15 +
 rtl/cu_data_read_engine_control_mc_rr_arbiter.sv | 41 ++++
 rtl/cu_data_read_engine_control_mc.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cu_data_read_engine_control_mc_pkg.sv
// rtl/cu_data_read_engine_control_mc_pkg.sv - shared types and constants for the multi-channel read engine
package cu_data_read_engine_control_mc_pkg;

    localparam int CACHELINE_ARRAY_NUM = 32;
    localparam int CACHELINE_SIZE      = 128;

    typedef enum logic [2:0] {
        CH_IDLE,
        CH_REQ,
        CH_WAIT,
        CH_PEND,
        CH_DONE
    } read_ch_state;

endpackage

// File: rtl/cu_data_read_engine_control_mc_rr_arbiter.sv
// rtl/cu_data_read_engine_control_mc_rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves past the winner
module cu_data_read_engine_control_mc_rr_arbiter #(
    parameter int N        = 4,
    parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clock,
    input  logic                rst,
    input  logic [N-1:0]        i_req,
    input  logic                i_advance,
    output logic [N-1:0]        o_grant,
    output logic [IDX_BITS-1:0] o_grant_idx
);

    logic [IDX_BITS-1:0] r_ptr;
    logic [IDX_BITS-1:0] w_idx;
    logic                w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_idx       = '0;
        w_found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_idx = r_ptr + IDX_BITS'(i);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (N == 1) ? '0 : o_grant_idx + IDX_BITS'(1);
        end
    end

endmodule

// File: rtl/cu_data_read_engine_control_mc.sv
// rtl/cu_data_read_engine_control_mc.sv - splits per-channel array reads into cacheline commands, tracks completions
module cu_data_read_engine_control_mc
    import cu_data_read_engine_control_mc_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int CH_BITS         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int ARRAY_SIZE_BITS = 32,
    parameter int ADDR_BITS       = 64,
    parameter int ELEMS_PER_CL    = CACHELINE_ARRAY_NUM,
    parameter int CL_BYTES        = CACHELINE_SIZE,
    parameter int MAX_OUTSTANDING = 16,
    parameter int WINDOW_BITS     = 16,
    localparam int OUT_BITS       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                    clock,
    input  logic                                    rst,
    input  logic                                    enable_in,
    input  logic [NUM_CHANNELS-1:0]                 job_start_in,
    input  logic [ADDR_BITS-1:0]                    job_base_in,
    input  logic [ARRAY_SIZE_BITS-1:0]              job_size_in,
    input  logic                                    window_en_in,
    input  logic [WINDOW_BITS-1:0]                  window_cl_in,
    input  logic                                    cmd_alfull_in,
    input  logic                                    data_alfull_in,
    input  logic                                    resp_valid_in,
    input  logic [CH_BITS-1:0]                      resp_channel_in,
    input  logic [ARRAY_SIZE_BITS-1:0]              resp_real_size_in,
    output logic                                    cmd_valid_out,
    output logic [ADDR_BITS-1:0]                    cmd_address_out,
    output logic [ARRAY_SIZE_BITS-1:0]              cmd_real_size_out,
    output logic [CH_BITS-1:0]                      cmd_channel_out,
    output logic                                    cmd_last_out,
    output logic [NUM_CHANNELS-1:0]                 ch_busy_out,
    output logic [NUM_CHANNELS-1:0]                 ch_done_out,
    output logic [NUM_CHANNELS*ARRAY_SIZE_BITS-1:0] ch_elems_done_out,
    output logic [OUT_BITS-1:0]                     outstanding_out,
    output logic                                    resp_error_out
);

    localparam logic [ARRAY_SIZE_BITS-1:0] ELEMS_CL = ARRAY_SIZE_BITS'(ELEMS_PER_CL);

    logic [WINDOW_BITS-1:0]                             w_win_limit;
    logic [NUM_CHANNELS-1:0]                            w_req;
    logic [NUM_CHANNELS-1:0]                            w_arb_grant;
    logic [NUM_CHANNELS-1:0]                            w_gnt;
    logic [NUM_CHANNELS-1:0]                            w_resp_hit;
    logic [CH_BITS-1:0]                                 w_gidx;
    logic                                               w_issue;
    logic                                               w_resp_ok;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]             w_ch_addr;
    logic [NUM_CHANNELS-1:0][ARRAY_SIZE_BITS-1:0]       w_ch_size;
    logic [NUM_CHANNELS-1:0]                            w_ch_last;

    logic                       r_cmd_valid;
    logic [ADDR_BITS-1:0]       r_cmd_addr;
    logic [ARRAY_SIZE_BITS-1:0] r_cmd_size;
    logic [CH_BITS-1:0]         r_cmd_ch;
    logic                       r_cmd_last;
    logic [OUT_BITS-1:0]        r_outstanding;
    logic                       r_resp_error;

    assign w_win_limit = (window_cl_in == '0) ? WINDOW_BITS'(1) : window_cl_in;
    assign w_issue     = enable_in & ~cmd_alfull_in & ~data_alfull_in &
                         (r_outstanding < OUT_BITS'(MAX_OUTSTANDING)) & (|w_req);
    assign w_gnt       = w_issue ? w_arb_grant : '0;
    assign w_resp_ok   = |w_resp_hit;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        read_ch_state               r_state;
        logic [ADDR_BITS-1:0]       r_base;
        logic [ADDR_BITS-1:0]       r_offset;
        logic [ARRAY_SIZE_BITS-1:0] r_remaining;
        logic [ARRAY_SIZE_BITS-1:0] r_elems;
        logic [OUT_BITS-1:0]        r_inflight;
        logic [WINDOW_BITS-1:0]     r_win_sent;
        logic                       r_done;
        logic                       w_win_full;

        assign w_win_full    = window_en_in && (r_win_sent >= w_win_limit);
        assign w_req[c]      = (r_state == CH_REQ) && (r_remaining != '0) && !w_win_full;
        // Responses for a channel with nothing in flight are dropped and flagged globally.
        assign w_resp_hit[c] = resp_valid_in && (resp_channel_in == CH_BITS'(c)) && (r_inflight != '0);
        assign w_ch_addr[c]  = r_base + r_offset;
        assign w_ch_size[c]  = (r_remaining < ELEMS_CL) ? r_remaining : ELEMS_CL;
        assign w_ch_last[c]  = (r_remaining <= ELEMS_CL);
        assign ch_busy_out[c] = (r_state != CH_IDLE);
        assign ch_done_out[c] = r_done;
        assign ch_elems_done_out[c*ARRAY_SIZE_BITS +: ARRAY_SIZE_BITS] = r_elems;

        always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
                r_state     <= CH_IDLE;
                r_base      <= '0;
                r_offset    <= '0;
                r_remaining <= '0;
                r_elems     <= '0;
                r_inflight  <= '0;
                r_win_sent  <= '0;
                r_done      <= 1'b0;
            end else begin
                if (w_gnt[c]) begin
                    r_remaining <= r_remaining - w_ch_size[c];
                    r_offset    <= r_offset + ADDR_BITS'(CL_BYTES);
                    r_win_sent  <= r_win_sent + WINDOW_BITS'(1);
                end
                r_inflight <= r_inflight + OUT_BITS'(w_gnt[c]) - OUT_BITS'(w_resp_hit[c]);
                if (w_resp_hit[c]) begin
                    r_elems <= r_elems + resp_real_size_in;
                end
                case (r_state)
                    CH_IDLE: begin
                        if (job_start_in[c]) begin
                            r_base      <= job_base_in;
                            r_remaining <= job_size_in;
                            r_offset    <= '0;
                            r_win_sent  <= '0;
                            r_elems     <= '0;
                            r_done      <= (job_size_in == '0);
                            r_state     <= (job_size_in == '0) ? CH_DONE : CH_REQ;
                        end
                    end
                    CH_REQ: begin
                        if (r_remaining == '0) begin
                            r_state <= CH_PEND;
                        end else if (w_win_full) begin
                            r_state <= CH_WAIT;
                        end
                    end
                    CH_WAIT: begin
                        if (r_inflight == '0) begin
                            r_win_sent <= '0;
                            r_state    <= (r_remaining == '0) ? CH_PEND : CH_REQ;
                        end
                    end
                    CH_PEND: begin
                        if (r_inflight == '0) begin
                            r_done  <= 1'b1;
                            r_state <= CH_DONE;
                        end
                    end
                    default: r_state <= CH_IDLE;
                endcase
            end
        end
    end

    cu_data_read_engine_control_mc_rr_arbiter #(
        .N        (NUM_CHANNELS),
        .IDX_BITS (CH_BITS)
    ) u_arb (
        .clock       (clock),
        .rst         (rst),
        .i_req       (w_req),
        .i_advance   (w_issue),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_gidx)
    );

    // A grant and an accepted response in the same cycle cancel in the global count.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_cmd_valid   <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_size    <= '0;
            r_cmd_ch      <= '0;
            r_cmd_last    <= 1'b0;
            r_outstanding <= '0;
            r_resp_error  <= 1'b0;
        end else begin
            r_cmd_valid   <= w_issue;
            r_outstanding <= r_outstanding + OUT_BITS'(w_issue) - OUT_BITS'(w_resp_ok);
            if (w_issue) begin
                r_cmd_addr <= w_ch_addr[w_gidx];
                r_cmd_size <= w_ch_size[w_gidx];
                r_cmd_ch   <= w_gidx;
                r_cmd_last <= w_ch_last[w_gidx];
            end
            if (resp_valid_in && !w_resp_ok) begin
                r_resp_error <= 1'b1;
            end
        end
    end

    assign cmd_valid_out     = r_cmd_valid;
    assign cmd_address_out   = r_cmd_addr;
    assign cmd_real_size_out = r_cmd_size;
    assign cmd_channel_out   = r_cmd_ch;
    assign cmd_last_out      = r_cmd_last;
    assign outstanding_out   = r_outstanding;
    assign resp_error_out    = r_resp_error;

endmodule
